// File: rtl/gas_engine_pkg.sv
// gas_engine_pkg: shared types and constants for the gas-engine serial link.
//   gas_shift_state_t   - controller states IDLE / SHIFT / DONE
//   GAS_SHIFT_W_DEFAULT - default word width of the shift controller
package gas_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } gas_shift_state_t;

    localparam int GAS_SHIFT_W_DEFAULT = 8;

endpackage

// File: rtl/gas_shift_reg.sv
// gas_shift_reg: parallel-load, right-shift register with asynchronous clear.
//   clk, rst_n - clock, asynchronous active-low clear
//   shift      - shift right, shiftin enters bit S-1 (wins over load)
//   load       - load loadin in parallel
//   shiftin    - serial input bit
//   loadin     - parallel load word
//   data       - current register contents
module gas_shift_reg #(
    parameter int S = gas_engine_pkg::GAS_SHIFT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift,
    input  logic         load,
    input  logic         shiftin,
    input  logic [S-1:0] loadin,
    output logic [S-1:0] data
);

    logic [S-1:0] data_q, data_d;

    always_comb begin
        data_d = shift ? {shiftin, data_q[S-1:1]} : (load ? loadin : data_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/gas_shift_ctrl.sv
// gas_shift_ctrl: full-duplex word transfer sequencer around gas_shift_reg.
//   clk, rst_n     - clock, asynchronous active-low reset
//   tx_data        - word to transmit, taken when tx_valid && tx_ready
//   tx_valid       - transmit request
//   tx_ready       - high in IDLE
//   sdi, sdo       - serial in / out (sdo is reg bit 0 during SHIFT, else 0)
//   shift_active   - a shift happens at the closing edge of this cycle
//   abort          - cancel a transfer in SHIFT
//   rx_data        - last completed received word
//   rx_valid       - one-cycle pulse when rx_data updates
//   busy           - high in SHIFT and DONE
module gas_shift_ctrl
    import gas_engine_pkg::*;
#(
    parameter int S = GAS_SHIFT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [S-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic         sdi,
    output logic         sdo,
    output logic         shift_active,
    input  logic         abort,
    output logic [S-1:0] rx_data,
    output logic         rx_valid,
    output logic         busy
);

    localparam int CW = $clog2(S);
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    gas_shift_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [S-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             shift, load;
    logic [S-1:0]     data;

    gas_shift_reg #(.S(S)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .load    (load),
        .shiftin (sdi),
        .loadin  (tx_data),
        .data    (data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shift = 1'b1;
                    // Counter saturates at LAST; the edge seen at LAST is the S-th shift.
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rx_data_d  = data;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign shift_active = shift;
    assign sdo          = (state_q == SHIFT) ? data[0] : 1'b0;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_gas_shift_ctrl.sv
// tb_gas_shift_ctrl: directed self-checking bench for gas_shift_ctrl (S=8 and S=2).
module tb_gas_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, sdi, sdo, shift_active, rx_valid, busy;
    logic       abort = 1'b0;
    logic [7:0] rx_data;
    logic       lb = 1'b0;
    logic       sdi_v = 1'b0;

    logic [1:0] tx_data2 = '0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, sdo2, shift_active2, rx_valid2, busy2;
    logic [1:0] rx_data2;

    int checks = 0;
    int failures = 0;

    assign sdi = lb ? sdo : sdi_v;

    always #5 clk = ~clk;

    gas_shift_ctrl #(.S(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .sdi(sdi), .sdo(sdo), .shift_active(shift_active),
        .abort(abort), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    gas_shift_ctrl #(.S(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .sdi(sdo2), .sdo(sdo2), .shift_active(shift_active2),
        .abort(1'b0), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2)
    );

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_ready, sdo, shift_active, rx_valid, busy, rx_data} !== {5'b10000, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b sdo=%b sa=%b rv=%b busy=%b rx=%h need 1,0,0,0,0,00",
                     tx_ready, sdo, shift_active, rx_valid, busy, rx_data);
        end
        checks++;
        if ({tx_ready2, sdo2, rx_valid2, busy2, rx_data2} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs_s2 got rdy=%b sdo=%b rv=%b busy=%b rx=%b", tx_ready2, sdo2, rx_valid2, busy2, rx_data2);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] exp_sdo = 8'b1010_0101;
        lb = 1'b1;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (c <= 8) begin
                checks++;
                if (sdo !== exp_sdo[c-1] || shift_active !== 1'b1 || rx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL loopback_shift cycle %0d got sdo=%b sa=%b rv=%b need sdo=%b sa=1 rv=0",
                             c, sdo, shift_active, rx_valid, exp_sdo[c-1]);
                end
            end else if (c == 9) begin
                checks++;
                if (busy !== 1'b1 || shift_active !== 1'b0 || sdo !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL loopback_done got busy=%b sa=%b sdo=%b rv=%b rdy=%b need 1,0,0,0,0",
                             busy, shift_active, sdo, rx_valid, tx_ready);
                end
            end else if (c == 10) begin
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || tx_ready !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL loopback_rx got rv=%b rx=%h rdy=%b busy=%b need 1,a5,1,0", rx_valid, rx_data, tx_ready, busy);
                end
            end else begin
                checks++;
                if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
                    failures++;
                    $display("FAIL loopback_pulse got rv=%b rx=%h need 0,a5", rx_valid, rx_data);
                end
            end
        end
    endtask

    task automatic test_fixed_input();
        lb = 1'b0;
        sdi_v = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            checks++;
            if (c <= 9) begin
                if (busy !== 1'b1 || sdo !== 1'b0) begin
                    failures++;
                    $display("FAIL fixed_busy cycle %0d got busy=%b sdo=%b need 1,0", c, busy, sdo);
                end
            end else if (busy !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'hFF) begin
                failures++;
                $display("FAIL fixed_rx got busy=%b rv=%b rx=%h need 0,1,ff", busy, rx_valid, rx_data);
            end
        end
        sdi_v = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        lb = 1'b1;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (tx_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_hold cycle %0d got rdy=%b busy=%b need 0,1", c, tx_ready, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got rv=%b rx=%h rdy=%b need 1,3c,1", rx_valid, rx_data, tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || shift_active !== 1'b1 || sdo !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_edge10 got busy=%b sa=%b sdo=%b need 1,1,1", busy, shift_active, sdo);
        end
        for (int c = 12; c <= 19; c++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL b2b_no_early_rx got %0d pulses need 0", pulses);
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_second got rv=%b rx=%h need 1,c3", rx_valid, rx_data);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        lb = 1'b0;
        sdi_v = 1'b0;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        abort = 1'b1;
        #1;
        checks++;
        if (shift_active !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_shift got sa=%b need 0", shift_active);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || sdo !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got rdy=%b busy=%b sdo=%b need 1,0,0", tx_ready, busy, sdo);
        end
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || rx_data !== 8'hC3 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_hold cycle %0d got rv=%b rx=%h busy=%b need 0,c3,0", c, rx_valid, rx_data, busy);
            end
        end
        lb = 1'b1;
        tx_data = 8'h81;
        tx_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
            failures++;
            $display("FAIL abort_next_xfer got rv=%b rx=%h need 1,81", rx_valid, rx_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        lb = 1'b0;
        sdi_v = 1'b1;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_ready, sdo, shift_active, rx_valid, busy, rx_data} !== {5'b10000, 8'h00}) begin
            failures++;
            $display("FAIL reset_mid_async got rdy=%b sdo=%b sa=%b rv=%b busy=%b rx=%h need 1,0,0,0,0,00",
                     tx_ready, sdo, shift_active, rx_valid, busy, rx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rx_valid || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_discard got %0d active cycles need 0", pulses);
        end
        lb = 1'b1;
        sdi_v = 1'b0;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            failures++;
            $display("FAIL reset_mid_recover got rv=%b rx=%h need 1,5a", rx_valid, rx_data);
        end
        @(negedge clk);
    endtask

    task automatic test_min_width();
        logic [1:0] exp_sdo = 2'b10;
        tx_data2 = 2'b10;
        tx_valid2 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tx_valid2 = 1'b0;
            checks++;
            if (c <= 2) begin
                if (sdo2 !== exp_sdo[c-1] || shift_active2 !== 1'b1) begin
                    failures++;
                    $display("FAIL minw_shift cycle %0d got sdo=%b sa=%b need %b,1", c, sdo2, shift_active2, exp_sdo[c-1]);
                end
            end else if (c == 3) begin
                if (busy2 !== 1'b1 || shift_active2 !== 1'b0 || rx_valid2 !== 1'b0) begin
                    failures++;
                    $display("FAIL minw_done got busy=%b sa=%b rv=%b need 1,0,0", busy2, shift_active2, rx_valid2);
                end
            end else if (rx_valid2 !== 1'b1 || rx_data2 !== 2'b10 || tx_ready2 !== 1'b1) begin
                failures++;
                $display("FAIL minw_rx got rv=%b rx=%b rdy=%b need 1,10,1", rx_valid2, rx_data2, tx_ready2);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_fixed_input();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_min_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gas_shift_ctrl.md
# gas_shift_ctrl

Sequencing controller for the gas-engine serial link. It wraps one parallel-load, right-shift register and runs full-duplex word transfers. Each transfer accepts a parallel word through a valid/ready handshake, loads it, and shifts it out LSB-first for exactly S cycles. While doing so it captures S incoming serial bits, then presents the received word with a one-cycle valid pulse. It sits between the gas-engine control logic (parallel side) and the sensor/actuator serial line.

## Interface
- S, default 8: word width and number of shifts per transfer; legal range S ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- tx_data  in  S  word to transmit; sampled on the accept edge.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  controller can accept; high only in IDLE.
- sdi  in  1  serial input; sampled on each shift edge.
- sdo  out  1  serial output; equals shift register bit 0 while in SHIFT, otherwise 0.
- shift_active  out  1  high on every cycle in which a shift occurs at the closing edge.
- abort  in  1  synchronous cancel of a transfer in progress.
- rx_data  out  S  last completed received word; held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high in SHIFT and DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - tx_ready=1.
  - If tx_valid is high at a clk edge, the register loads tx_data, the bit counter clears to 0, and the state goes to SHIFT.
- **SHIFT**
  - shift_active=1 and sdo=reg[0].
  - Each edge: reg shifts right, reg[S-1] takes sdi, and the counter increments.
  - When the counter equals S-1 at an edge, the state goes to DONE. That edge performs the S-th shift.
- **DONE**
  - rx_data is loaded from reg at the exit edge, so rx_valid is high during the following cycle. rx_valid is registered and high for exactly one cycle.
  - The next state is always IDLE.
- **Abort**
  - abort=1 in SHIFT forces IDLE at the next edge.
  - That edge performs no shift. rx_data and rx_valid are untouched. reg keeps its content.
  - abort is ignored in IDLE and DONE.
- **Word ordering:** the first received bit ends in rx_data[0] and the last in rx_data[S-1].
- **Counter:** width $clog2(S). It never wraps past S-1 and clears on every accept and on abort.
- **Simultaneous events:**
  - tx_valid while not IDLE is ignored; the upstream holds it.
  - In the sub-module, shift has priority over load if both are asserted. The controller never asserts both.

## Timing
- Accept at edge 0 starts the transfer.
  - SHIFT occupies cycles 1..S.
  - DONE occupies cycle S+1.
  - rx_valid is high in cycle S+2, coinciding with IDLE and tx_ready=1.
- Back-to-back transfers are accepted every S+2 cycles.
- sdo changes only on clk edges, so the peer samples it at the same edge that samples sdi.
- **Reset (rst_n low, asynchronous, any state):**
  - State goes to IDLE and reg, counter and rx_data clear to 0.
  - rx_valid=0, sdo=0, shift_active=0, busy=0, tx_ready=1.
  - Reset mid-transfer discards the transfer; no rx_valid is produced.

## Structure
- Shared package gas_engine_pkg holds:
  - typedef enum gas_shift_state_t {IDLE, SHIFT, DONE};
  - constant GAS_SHIFT_W_DEFAULT = 8.
- Sub-module gas_shift_reg#(S):
  - Ports: clk, rst_n, shift, load, shiftin, loadin[S-1:0], data[S-1:0].
  - Behaviour: right shift with shiftin into bit S-1; shift over load priority; asynchronous clear.
- The controller holds the FSM, the counter and the rx_data/rx_valid registers. sdo is taken from data[0].

## Test plan
- **Loopback:** S=8, sdi=sdo, tx_data=8'hA5 accepted at edge 0.
  - sdo over cycles 1..8 reads 1,0,1,0,0,1,0,1.
  - rx_data=8'hA5 and rx_valid=1 only in cycle 10.
- **Fixed input:** sdi tied 1, tx_data=8'h00 → rx_data=8'hFF; sdo=0 on all shift cycles; busy high for cycles 1..9.
- **Back-to-back:** tx_valid held high with 8'h3C then 8'hC3.
  - The second word is accepted at edge 10, exactly S+2 after the first.
  - Receive with loopback yields 8'h3C, then 8'hC3.
  - tx_valid asserted while busy is never accepted.
- **Abort:** abort asserted in cycle 4 of a 8'hFF transfer.
  - State is IDLE in cycle 5; no rx_valid; rx_data keeps its previous value.
  - A following 8'h81 loopback transfer completes with rx_data=8'h81.
- **Reset mid-transfer:** rst_n driven low mid-cycle during cycle 5 of a transfer.
  - All outputs take their reset values immediately, without waiting for an edge.
  - After release, a new 8'h5A transfer completes normally.
- **Minimum width:** S=2, loopback of 2'b10 → sdo sequence 0,1; rx_data=2'b10 in cycle 4.
